// File: rtl/led_pkg.sv
// Shared LED divider types: exponent width, match counter and FSM encoding.
// Used by both the led_cnt generator and the led_blink_decoder receiver.
package led_pkg;

    localparam int DIV_W   = 5;
    localparam int MATCH_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } led_state_t;

endpackage

// File: rtl/led_pow2_enc.sv
// Power-of-two classifier for a measured half-period.
// Reports the set-bit index and whether it lies in [MIN_DIV, MAX_DIV].
module led_pow2_enc
    import led_pkg::*;
#(
    parameter int P_W     = 32,
    parameter int MIN_DIV = 1,
    parameter int MAX_DIV = 31
) (
    input  logic [P_W-1:0]   p,
    output logic             is_pow2,
    output logic [DIV_W-1:0] k
);

    logic             one_hot;
    logic [DIV_W-1:0] idx;

    always_comb begin
        idx = '0;
        for (int i = 0; i < P_W; i++) begin
            if (p[i]) begin
                idx = DIV_W'(i);
            end
        end
    end

    assign one_hot = (p != '0) && ((p & (p - P_W'(1))) == '0);
    assign k       = idx;
    assign is_pow2 = one_hot
                  && (int'(idx) >= MIN_DIV)
                  && (int'(idx) <= MAX_DIV);

endmodule

// File: rtl/led_blink_decoder.sv
// Recovers the led_cnt divider exponent from the observed LED half-period.
// Define LED_DEC_SYNC_EN to put a 2-flop synchronizer in front of led_i.
module led_blink_decoder
    import led_pkg::*;
#(
    parameter int LOCK_N  = 4,
    parameter int MIN_DIV = 1,
    parameter int MAX_DIV = 31
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             led_i,
    output logic [DIV_W-1:0] div_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_o
);

    localparam int CNT_W = MAX_DIV + 1;
    localparam logic [CNT_W-1:0]   TMO    = {1'b1, {MAX_DIV{1'b0}}};
    localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_N);

    logic led_s;

`ifdef LED_DEC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], led_i};
        end
    end

    assign led_s = sync_q[1];
`else
    assign led_s = led_i;
`endif

    logic               led_q;
    logic [CNT_W-1:0]   cnt;
    led_state_t         state_q, state_d;
    logic [DIV_W-1:0]   cand_q, cand_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               locked_q, locked_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic               led_edge;
    logic               timeout;
    logic [CNT_W-1:0]   p;
    logic               is_pow2;
    logic [DIV_W-1:0]   k;

    assign led_edge = led_s ^ led_q;
    assign timeout  = (cnt == TMO) && !led_edge;
    assign p        = cnt + CNT_W'(1);

    led_pow2_enc #(
        .P_W     (CNT_W),
        .MIN_DIV (MIN_DIV),
        .MAX_DIV (MAX_DIV)
    ) u_enc (
        .p       (p),
        .is_pow2 (is_pow2),
        .k       (k)
    );

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            led_q <= 1'b0;
            cnt   <= '0;
        end else begin
            led_q <= led_s;
            cnt   <= led_edge ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            match_q  <= '0;
            div_q    <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            div_q    <= div_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        div_d    = div_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (led_edge) begin
                    state_d = MEASURE;
                    match_d = '0;
                end
            end
            MEASURE: begin
                if (led_edge) begin
                    if (!is_pow2) begin
                        err_d   = 1'b1;
                        match_d = '0;
                    end else begin
                        cand_d = k;
                        if (k == cand_q || match_q == '0) begin
                            match_d = match_q + MATCH_W'(1);
                        end else begin
                            match_d = MATCH_W'(1);
                        end
                        if (match_d >= LOCK_M) begin
                            div_d    = k;
                            locked_d = 1'b1;
                            valid_d  = 1'b1;
                            state_d  = LOCKED;
                        end
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (led_edge) begin
                    if (is_pow2 && k == div_q) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                        match_d  = is_pow2 ? MATCH_W'(1) : '0;
                        if (is_pow2) begin
                            cand_d = k;
                        end
                    end
                end else if (timeout) begin
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign div_o    = div_q;
    assign locked_o = locked_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_led_blink_decoder.sv
// Directed bench for led_blink_decoder built with MAX_DIV=8.
// Pulse counters sample on the falling edge; levels are sampled 1ns after rise.
module tb_led_blink_decoder;
    import led_pkg::*;

    localparam int LOCK_N  = 4;
    localparam int MIN_DIV = 1;
    localparam int MAX_DIV = 8;
`ifdef LED_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk100 = 1'b0;
    logic             rst    = 1'b1;
    logic             led_i  = 1'b0;
    logic [DIV_W-1:0] div_o;
    logic             valid_o;
    logic             locked_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;

    led_blink_decoder #(
        .LOCK_N  (LOCK_N),
        .MIN_DIV (MIN_DIV),
        .MAX_DIV (MAX_DIV)
    ) dut (
        .clk100   (clk100),
        .rst      (rst),
        .led_i    (led_i),
        .div_o    (div_o),
        .valid_o  (valid_o),
        .locked_o (locked_o),
        .err_o    (err_o)
    );

    always #5 clk100 = ~clk100;

    always @(negedge clk100) begin
        if (valid_o) n_valid++;
        if (err_o) n_err++;
        if (valid_o && err_o) n_both++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic toggle_run(input int n);
        led_i = ~led_i;
        step(n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        led_i = 1'b0;
        step(3);
        checks++;
        if (div_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_div: got %0d expected 0", div_o);
        end
        checks++;
        if ({valid_o, locked_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000",
                     {valid_o, locked_o, err_o});
        end
        rst = 1'b0;
        step(4);
        checks++;
        if (n_err !== 0 || n_valid !== 0) begin
            errors++;
            $display("FAIL reset_idle: err=%0d valid=%0d expected 0 0",
                     n_err, n_valid);
        end
    endtask

    task automatic test_lock8;
        int e0, v0;
        e0 = n_err;
        v0 = n_valid;
        repeat (4) toggle_run(8);
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("FAIL lock8_early: locked=%b expected 0", locked_o);
        end
        toggle_run(LAT);
        checks++;
        if (locked_o !== 1'b1 || div_o !== 5'd3 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL lock8_lock: locked=%b div=%0d valid=%b expected 1 3 1",
                     locked_o, div_o, valid_o);
        end
        step(8 - LAT);
        repeat (3) toggle_run(8);
        checks++;
        if (n_valid - v0 !== 4 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL lock8_pulses: valid=%0d err=%0d expected 4 0",
                     n_valid - v0, n_err - e0);
        end
    endtask

    task automatic test_relock32;
        int e0, v0;
        e0 = n_err;
        v0 = n_valid;
        step(24);
        toggle_run(LAT);
        checks++;
        if (err_o !== 1'b1 || locked_o !== 1'b0 || div_o !== 5'd3) begin
            errors++;
            $display("FAIL relock32_loss: err=%b locked=%b div=%0d expected 1 0 3",
                     err_o, locked_o, div_o);
        end
        step(32 - LAT);
        repeat (2) toggle_run(32);
        checks++;
        if (locked_o !== 1'b0 || div_o !== 5'd3) begin
            errors++;
            $display("FAIL relock32_hold: locked=%b div=%0d expected 0 3",
                     locked_o, div_o);
        end
        toggle_run(LAT);
        checks++;
        if (locked_o !== 1'b1 || div_o !== 5'd5 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL relock32_lock: locked=%b div=%0d valid=%b expected 1 5 1",
                     locked_o, div_o, valid_o);
        end
        step(32 - LAT);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 1) begin
            errors++;
            $display("FAIL relock32_pulses: err=%0d valid=%0d expected 1 1",
                     n_err - e0, n_valid - v0);
        end
    endtask

    task automatic test_timeout;
        int e0, v0;
        repeat (5) toggle_run(8);
        checks++;
        if (locked_o !== 1'b1 || div_o !== 5'd3) begin
            errors++;
            $display("FAIL timeout_relock: locked=%b div=%0d expected 1 3",
                     locked_o, div_o);
        end
        step(LAT + 248);
        checks++;
        if (err_o !== 1'b0 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err=%b locked=%b expected 0 1",
                     err_o, locked_o);
        end
        step(1);
        checks++;
        if (err_o !== 1'b1 || locked_o !== 1'b0 || div_o !== 5'd3) begin
            errors++;
            $display("FAIL timeout_fire: err=%b locked=%b div=%0d expected 1 0 3",
                     err_o, locked_o, div_o);
        end
        step(1);
        e0 = n_err;
        v0 = n_valid;
        toggle_run(LAT + 2);
        checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 0 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle_edge: err=%0d valid=%0d locked=%b expected 0 0 0",
                     n_err - e0, n_valid - v0, locked_o);
        end
        step(256 - LAT - 2);
    endtask

    task automatic test_max_div;
        int e0;
        e0 = n_err;
        repeat (3) toggle_run(256);
        checks++;
        if (locked_o !== 1'b0 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL maxdiv_early: locked=%b err=%0d expected 0 0",
                     locked_o, n_err - e0);
        end
        toggle_run(LAT);
        checks++;
        if (locked_o !== 1'b1 || div_o !== 5'd8 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL maxdiv_lock: locked=%b div=%0d valid=%b expected 1 8 1",
                     locked_o, div_o, valid_o);
        end
        step(257 - LAT);
        toggle_run(LAT);
        checks++;
        if (err_o !== 1'b1 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL edge_wins_err: err=%b locked=%b expected 1 0",
                     err_o, locked_o);
        end
        step(8 - LAT);
        repeat (3) toggle_run(8);
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("FAIL edge_wins_early: locked=%b expected 0", locked_o);
        end
        toggle_run(LAT);
        checks++;
        if (locked_o !== 1'b1 || div_o !== 5'd3) begin
            errors++;
            $display("FAIL edge_wins_measure: locked=%b div=%0d expected 1 3",
                     locked_o, div_o);
        end
        step(8 - LAT);
        checks++;
        if (n_err - e0 !== 1) begin
            errors++;
            $display("FAIL maxdiv_errs: got %0d expected 1", n_err - e0);
        end
    endtask

    task automatic test_bad12;
        int e0, v0;
        step(4);
        e0 = n_err;
        v0 = n_valid;
        repeat (4) toggle_run(12);
        checks++;
        if (n_err - e0 !== 4 || n_valid - v0 !== 0 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL bad12: err=%0d valid=%0d locked=%b expected 4 0 0",
                     n_err - e0, n_valid - v0, locked_o);
        end
    endtask

    task automatic test_fast;
        int e0, v0;
        e0 = n_err;
        v0 = n_valid;
        repeat (8) toggle_run(1);
        step(LAT + 2);
        checks++;
        if (n_err - e0 !== 8 || n_valid - v0 !== 0 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL fast_p1: err=%0d valid=%0d locked=%b expected 8 0 0",
                     n_err - e0, n_valid - v0, locked_o);
        end
    endtask

    task automatic test_reset_mid;
        int e0;
        step(5 - LAT);
        repeat (4) toggle_run(8);
        checks++;
        if (locked_o !== 1'b1 || div_o !== 5'd3) begin
            errors++;
            $display("FAIL rstmid_prelock: locked=%b div=%0d expected 1 3",
                     locked_o, div_o);
        end
        step(3);
        rst = 1'b1;
        led_i = 1'b1;
        #1;
        checks++;
        if ({div_o, valid_o, locked_o, err_o} !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_clear: div=%0d v=%b l=%b e=%b expected all 0",
                     div_o, valid_o, locked_o, err_o);
        end
        step(2);
        e0 = n_err;
        rst = 1'b0;
        step(8);
        repeat (3) toggle_run(8);
        checks++;
        if (locked_o !== 1'b0 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL rstmid_early: locked=%b err=%0d expected 0 0",
                     locked_o, n_err - e0);
        end
        toggle_run(LAT);
        checks++;
        if (locked_o !== 1'b1 || div_o !== 5'd3 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_lock: locked=%b div=%0d valid=%b expected 1 3 1",
                     locked_o, div_o, valid_o);
        end
        step(8 - LAT);
        checks++;
        if (n_both !== 0) begin
            errors++;
            $display("FAIL exclusive: both-high cycles=%0d expected 0", n_both);
        end
    endtask

    initial begin
        test_reset;
        test_lock8;
        test_relock32;
        test_timeout;
        test_max_div;
        test_bad12;
        test_fast;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
